alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Multi-cycle RV32M sequencer (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) that reuses the existing shared 32-bit ALU.
//  Drives the ALU as an add/sub engine; this block holds only registers, shifting and sign control, no adder of its own.
//  Sits beside the ALU in the execute stage; the core stalls while busy=1.
// PARAMETERS
//  XLEN   32  datapath width; fixed to the ALU width
//  CNT_W  6   iteration counter width; must hold XLEN
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous active-low reset
//  start      in   1     request; sampled only in IDLE
//  kill       in   1     abort current op (pipeline flush)
//  funct3     in   3     RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  op_a/op_b  in   32    rs1/rs2 values, sampled with start
//  busy       out  1     op in flight (not IDLE)
//  done       out  1     one-cycle pulse; result valid the same cycle
//  result     out  32    final value; holds until the next done
//  unsupp     out  1     one-cycle pulse for a compiled-out op
//  alu_a      out  32    to ALU rs1
//  alu_b      out  32    to ALU b
//  alu_fn     out  4     to ALU alufn; only 4'b0000 add or 4'b0001 sub
//  alu_shamt  out  5     to ALU Instruction[24:20]; constant 0
//  alu_r      in   32    ALU r
//  alu_cf     in   1     ALU cf; for sub, 1 = no borrow
// BEHAVIOUR
//  Reset (async): state IDLE; busy, done, unsupp = 0; result, hi, lo, cnt = 0; alu_a/alu_b = 0; alu_fn = 0000.
//  FSM: IDLE -> NEG_A -> NEG_B -> RUN (x32) -> FIX_LO -> FIX_HI -> DONE -> IDLE.
//  Every state is always visited, so latency is fixed: start sampled at edge 0 gives done in cycle 37.
//  Signs: sa = op_a[31] for MUL-H/HSU/DIV/REM; sb = op_b[31] for MULH/DIV/REM only.
//    Negate flag: neg = sa^sb for MUL*/DIV; neg = sa for REM.
//  NEG_A: ALU 0 - a (sub); store if sa. NEG_B: ALU 0 - b; store if sb.
//  RUN, MUL: ALU hi + (lo[0] ? mcand : 0) (add); {hi,lo} <= {alu_cf, alu_r, lo[31:1]}.
//  RUN, DIV: trial = {hi[30:0], lo[31]}; ALU trial - divisor (sub).
//    acc = alu_cf | hi[31]; hi <= acc ? alu_r : trial; lo <= {lo[30:0], acc}.
//  FIX_LO: ALU 0 - lo; if neg and op is not REM, lo <= alu_r and c <= alu_cf (c is 1 iff lo == 0).
//  FIX_HI: ALU ~hi + {31'b0,c}, with c forced to 1 for REM; hi <= alu_r if neg and op is MULH/MULHSU/REM.
//  DONE: result = lo for MUL/DIV/DIVU, hi for the other five ops; done = 1.
//  Divide by zero: IDLE -> DONE directly (done in cycle 1).
//    DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a. No ALU use.
//  Overflow: 0x80000000 / -1 yields 0x80000000 with REM 0, with no special path.
//  start while busy: ignored. start and kill in the same IDLE cycle: kill wins, start ignored.
//  kill in any non-IDLE state: IDLE next cycle, no done, result unchanged.
//  Reset mid-op: immediate return to the reset state.
// CONFIGURATION
//  MULDIV_DIV_EN defined: full behaviour above.
//  Undefined: funct3[2]=1 goes IDLE -> DONE with result 0 and unsupp = 1 for one cycle; divide datapath removed.
//    MUL ops are unaffected.
// STRUCTURE
//  Package riscv_muldiv_pkg: funct3 localparams; ALU_ADD = 4'b0000 and ALU_SUB = 4'b0001; state encoding enum.
//  One sub-module is natural: muldiv_ctrl (FSM + cnt + neg/c flags); operand and ALU muxes stay in the top.
// TESTING
//  MUL 7 x -3 -> result 0xFFFFFFEB, done exactly in cycle 37; alu_fn only ever 0000/0001.
//  MULH 0x80000000^2 -> 0x40000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 0xFFFFFFFF/0x80000001 -> 0x7FFFFFFE.
//  DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done in cycle 1; DIV 0x80000000/-1 -> 0x80000000.
//  kill in cycle 10 -> busy 0 in cycle 11, no done; start pulsed mid-op is ignored.
//  rst_n low in cycle 20 -> all outputs 0 asynchronously; a new MUL afterwards completes correctly.

Source files
------------

// File: rtl/riscv_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 codes,
// the two ALU function codes it drives, the sequencer state encoding and the
// operand-signedness decode.
package riscv_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEG_A  = 3'd1,
    ST_NEG_B  = 3'd2,
    ST_RUN    = 3'd3,
    ST_FIX_LO = 3'd4,
    ST_FIX_HI = 3'd5,
    ST_DONE   = 3'd6
  } muldiv_state_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq_ctrl.sv
// Sequencer control for alu_muldiv_seq: state machine, iteration counter,
// latched funct3, operand sign flags, result-negate flag and the low-word
// carry used when negating a 64-bit product.
module muldiv_ctrl
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          kill,
  input  logic [2:0]    funct3,
  input  logic          a_msb,
  input  logic          b_msb,
  input  logic          fast_req,
  input  logic          fast_unsupp,
  input  logic          alu_cf,
  output muldiv_state_e state,
  output logic [2:0]    f3,
  output logic          sa,
  output logic          sb,
  output logic          neg,
  output logic          c_flag,
  output logic          busy,
  output logic          done,
  output logic          unsupp
);

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic             sa_q, sa_d, sb_q, sb_d, neg_q, neg_d, c_q, c_d;
  logic             busy_q, done_q, unsupp_q, unsupp_d;
  logic             sa_new, sb_new;

  assign sa_new = a_msb & a_is_signed(funct3);
  assign sb_new = b_msb & b_is_signed(funct3);

  // Next-state, counter and flag computation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    neg_d    = neg_q;
    c_d      = c_q;
    unsupp_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !kill) begin
          f3_d  = funct3;
          sa_d  = sa_new;
          sb_d  = sb_new;
          neg_d = (funct3 == F3_REM) ? sa_new : (sa_new ^ sb_new);
          if (fast_req) begin
            state_d  = ST_DONE;
            unsupp_d = fast_unsupp;
          end else begin
            state_d = ST_NEG_A;
          end
        end
      end
      ST_NEG_A: state_d = ST_NEG_B;
      ST_NEG_B: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIX_LO;
      end
      ST_FIX_LO: begin
        state_d = ST_FIX_HI;
        // 0 - lo produces no borrow only when lo is zero: that is the carry into hi
        if (neg_q && (f3_q != F3_REM)) c_d = alu_cf;
      end
      ST_FIX_HI: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (kill && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      unsupp_d = 1'b0;
    end
  end

  // Control state registers; status outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      neg_q    <= 1'b0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      unsupp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      neg_q    <= neg_d;
      c_q      <= c_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      unsupp_q <= unsupp_d;
    end
  end

  assign state  = state_q;
  assign f3     = f3_q;
  assign sa     = sa_q;
  assign sb     = sb_q;
  assign neg    = neg_q;
  assign c_flag = c_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign unsupp = unsupp_q;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer that borrows the shared ALU as
// its only adder/subtractor. Operands are made positive, a 32-step shift-add
// or restoring-divide loop runs, then the 64-bit result is sign-corrected.
// Build option: define MULDIV_DIV_EN to include DIV/DIVU/REM/REMU; without it
// those funct3 codes complete immediately with result 0 and an unsupp pulse.
module alu_muldiv_seq
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            unsupp,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_fn,
  output logic [4:0]      alu_shamt,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_cf
);

  muldiv_state_e   state;
  logic [2:0]      f3;
  logic            sa, sb, neg, c_flag;
  logic            fast_req, fast_unsupp;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic            is_rem, hi_fix, lo_sel, c_eff;

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] div_trial;
  logic            div_acc;

  assign fast_req    = funct3[2] && (op_b == '0);
  assign fast_unsupp = 1'b0;
  assign fast_res    = funct3[1] ? op_a : '1;
  assign div_trial   = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
  // hi[31] set means the true 33-bit trial already exceeds any divisor
  assign div_acc     = alu_cf | hi_q[XLEN-1];
`else
  assign fast_req    = funct3[2];
  assign fast_unsupp = 1'b1;
  assign fast_res    = '0;
`endif

  assign is_rem = (f3 == F3_REM);
  assign hi_fix = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_REM);
  assign lo_sel = (f3 == F3_MUL) || (f3 == F3_DIV) || (f3 == F3_DIVU);
  assign c_eff  = c_flag | is_rem;

  muldiv_ctrl #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .kill        (kill),
    .funct3      (funct3),
    .a_msb       (op_a[XLEN-1]),
    .b_msb       (op_b[XLEN-1]),
    .fast_req    (fast_req),
    .fast_unsupp (fast_unsupp),
    .alu_cf      (alu_cf),
    .state       (state),
    .f3          (f3),
    .sa          (sa),
    .sb          (sb),
    .neg         (neg),
    .c_flag      (c_flag),
    .busy        (busy),
    .done        (done),
    .unsupp      (unsupp)
  );

  // ALU operand and function selection for the current state
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fn = ALU_ADD;
    unique case (state)
      ST_NEG_A: begin
        alu_b  = a_q;
        alu_fn = ALU_SUB;
      end
      ST_NEG_B: begin
        alu_b  = b_q;
        alu_fn = ALU_SUB;
      end
      ST_RUN: begin
`ifdef MULDIV_DIV_EN
        if (f3[2]) begin
          alu_a  = div_trial;
          alu_b  = b_q;
          alu_fn = ALU_SUB;
        end else
`endif
        begin
          alu_a = hi_q;
          alu_b = lo_q[0] ? b_q : '0;
        end
      end
      ST_FIX_LO: begin
        alu_b  = lo_q;
        alu_fn = ALU_SUB;
      end
      ST_FIX_HI: begin
        alu_a = ~hi_q;
        alu_b = {{(XLEN-1){1'b0}}, c_eff};
      end
      default: ;
    endcase
  end

  assign alu_shamt = '0;

  // Operand, accumulator and result register updates
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    unique case (state)
      ST_IDLE: begin
        if (start && !kill) begin
          a_d = op_a;
          b_d = op_b;
          if (fast_req) result_d = fast_res;
        end
      end
      ST_NEG_A: if (sa) a_d = alu_r;
      ST_NEG_B: begin
        if (sb) b_d = alu_r;
        hi_d = '0;
        lo_d = a_q;
      end
      ST_RUN: begin
`ifdef MULDIV_DIV_EN
        if (f3[2]) begin
          hi_d = div_acc ? alu_r : div_trial;
          lo_d = {lo_q[XLEN-2:0], div_acc};
        end else
`endif
        begin
          {hi_d, lo_d} = {alu_cf, alu_r, lo_q[XLEN-1:1]};
        end
      end
      ST_FIX_LO: if (neg && !is_rem) lo_d = alu_r;
      ST_FIX_HI: begin
        if (neg && hi_fix) hi_d = alu_r;
        result_d = lo_sel ? lo_q : hi_d;
      end
      default: ;
    endcase
    if (kill && (state != ST_IDLE)) result_d = result_q;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed-vector bench for alu_muldiv_seq with a behavioural shared ALU.
// Expected results follow the MULDIV_DIV_EN setting of the build.
module tb_alu_muldiv_seq;
  import riscv_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done, unsupp;
  logic [31:0] result, alu_a, alu_b, alu_r;
  logic [3:0]  alu_fn;
  logic [4:0]  alu_shamt;
  logic        alu_cf;
  logic [32:0] alu_sum;

  int errors = 0;
  int checks = 0;
  int bad_fn = 0;

  alu_muldiv_seq #(
    .XLEN  (32),
    .CNT_W (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .kill      (kill),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .unsupp    (unsupp),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_fn    (alu_fn),
    .alu_shamt (alu_shamt),
    .alu_r     (alu_r),
    .alu_cf    (alu_cf)
  );

  always #5 clk = ~clk;

  // shared ALU: add with carry out, or subtract with cf = no borrow
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    alu_r   = alu_sum[31:0];
    alu_cf  = alu_sum[32];
    if (alu_fn == 4'b0001) begin
      alu_r  = alu_a - alu_b;
      alu_cf = (alu_a >= alu_b);
    end
  end

  always @(negedge clk) begin
    if ((alu_fn !== 4'b0000 && alu_fn !== 4'b0001) || alu_shamt !== 5'd0) bad_fn++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // issue one op, optionally pulse start again at cycle poke_at, check the outcome
  task automatic op(input string tag, input logic [2:0] f, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                    input logic exp_u, input int poke_at);
    int   lat;
    logic u;
    lat = 0;
    u   = 1'b0;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (done) begin
        lat = n;
        u   = unsupp;
        break;
      end
      if (n == poke_at) begin
        start = 1'b1; funct3 = F3_MULHU; op_a = '1; op_b = '1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check({tag, " result"}, result, exp_res);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " unsupp"}, {31'd0, u}, {31'd0, exp_u});
    @(negedge clk);
    check({tag, " done pulse"}, {31'd0, done}, 32'd0);
    check({tag, " result hold"}, result, exp_res);
  endtask

  // divide-family op: the expectation collapses to the unsupported path when compiled out
  task automatic dop(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
`ifdef MULDIV_DIV_EN
    op(tag, f, a, b, exp_res, exp_lat, 1'b0, 0);
`else
    op(tag, f, a, b, 32'd0, 1, 1'b1, 0);
`endif
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
    check({tag, " done"}, {31'd0, done}, 32'd0);
    check({tag, " unsupp"}, {31'd0, unsupp}, 32'd0);
    check({tag, " result"}, result, 32'd0);
    check({tag, " alu_a"}, alu_a, 32'd0);
    check({tag, " alu_b"}, alu_b, 32'd0);
    check({tag, " alu_fn"}, {28'd0, alu_fn}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    rst_n = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // multiply family
    op("MUL 7*-3",       F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 37, 1'b0, 0);
    op("MUL poke",       F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 37, 1'b0, 5);

    // kill in cycle 10: idle in cycle 11, no done, result kept
    @(negedge clk);
    funct3 = F3_MUL; op_a = 32'd5; op_b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("kill busy before", {31'd0, busy}, 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill busy after", {31'd0, busy}, 32'd0);
    dc = 0;
    repeat (45) begin
      if (done) dc++;
      @(negedge clk);
    end
    check("kill no done", dc, 0);
    check("kill result kept", result, 32'hFFFFFFEB);

    // start and kill together in idle: nothing starts
    funct3 = F3_MUL; op_a = 32'd3; op_b = 32'd3; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("start+kill busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("start+kill done", {31'd0, done}, 32'd0);

    op("MULH min^2",     F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 37, 1'b0, 0);
    op("MULHU max^2",    F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 37, 1'b0, 0);
    op("MULHSU -1*max",  F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 37, 1'b0, 0);
    op("MULH -1*-1",     F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 37, 1'b0, 0);
    op("MULH -7*3",      F3_MULH,   32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 37, 1'b0, 0);
    op("MUL 12345678*10",F3_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 37, 1'b0, 0);

    // divide family
    dop("DIV -7/2",      F3_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 37);
    dop("REM -7/2",      F3_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 37);
    dop("DIVU 100/7",    F3_DIVU, 32'd100,      32'd7,        32'd14,       37);
    dop("REMU max/8..1", F3_REMU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 37);
    dop("DIV 5/0",       F3_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1);
    dop("REM 5/0",       F3_REM,  32'd5,        32'd0,        32'd5,        1);
    dop("DIV ovf",       F3_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 37);
    dop("REM ovf",       F3_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 37);
    dop("REM -4/2",      F3_REM,  32'hFFFFFFFC, 32'd2,        32'h00000000, 37);

    // asynchronous reset in cycle 20 of an op
    @(negedge clk);
    funct3 = F3_MUL; op_a = 32'h12345678; op_b = 32'h9ABCDEF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    op("MUL after reset", F3_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 37, 1'b0, 0);

    check("alu_fn legal", bad_fn, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
